// File: rtl/wb_split_pkg.sv
// Shared types and helpers for the Wishbone slave splitter.
//   state_t      : transaction FSM states (IDLE / REQ / RESP)
//   ERR_DATA_DEF : default read data for unmapped or timed-out accesses
//   sel_width()  : target index width, $clog2(NUM_SLAVES)
//   cnt_width()  : timeout counter width derived from TIMEOUT_CYC, clamped to 8..16
package wb_split_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned t);
    int unsigned w;
    w = $clog2(t + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/wb_split_decode.sv
// Combinational address decoder for the user-area splitter.
//   adr_hi : address bits [31:WIN_BITS]; the in-window offset is not needed here
//   hit    : address lies in the user area and selects an existing target
//   idx    : target index (valid when hit)
module wb_split_decode
  import wb_split_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned WIN_BITS   = 20,
  parameter int unsigned SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [31:WIN_BITS] adr_hi,
  output logic               hit,
  output logic [SEL_W-1:0]   idx
);

  localparam int unsigned FIELD_W = 24 - WIN_BITS;

  // The whole window field up to bit 23 is compared against NUM_SLAVES, so an
  // index that only aliases into range in its low SEL_W bits still misses.
  logic [FIELD_W-1:0] field;

  assign field = adr_hi[23:WIN_BITS];
  assign idx   = field[SEL_W-1:0];
  assign hit   = (adr_hi[31:24] == BASE_ADDR[31:24]) && (32'(field) < NUM_SLAVES);

endmodule

// File: rtl/wb_slave_splitter.sv
// Wishbone-classic slave splitter: one registered transaction at a time from the
// wbs_* port to one of NUM_SLAVES user-area targets; unmapped accesses are
// answered locally with ERR_DATA so the master is never left hung.
//   wb_clk_i, wb_rst_n_i        : clock, async active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i: master request
//   wbs_ack_o, wbs_dat_o        : 1-cycle ack and read data to master
//   m_cyc_o, m_stb_o            : per-target one-hot cycle/strobe
//   m_we/sel/adr/dat_o          : shared registered request to targets
//   m_dat_i, m_ack_i            : target read data (slave k at [32k+:32]) and acks
//   err_irq_o                   : sticky error; set by read miss / timeout,
//                                 cleared by a write miss
// Optional: define WB_SPLIT_TIMEOUT_EN to abandon a target after TIMEOUT_CYC
// cycles without ack.
module wb_slave_splitter
  import wb_split_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned WIN_BITS    = 20,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic [NUM_SLAVES-1:0]      m_cyc_o,
  output logic [NUM_SLAVES-1:0]      m_stb_o,
  output logic                       m_we_o,
  output logic [3:0]                 m_sel_o,
  output logic [31:0]                m_adr_o,
  output logic [31:0]                m_dat_o,
  input  logic [32*NUM_SLAVES-1:0]   m_dat_i,
  input  logic [NUM_SLAVES-1:0]      m_ack_i,
  output logic                       err_irq_o
);

  localparam int unsigned SEL_W = sel_width(NUM_SLAVES);

  state_t                state, state_nx;
  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_idx;
  logic [SEL_W-1:0]      idx_q;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic [31:0]           sel_rdata;
  logic [31:0]           rdata_q;
  logic                  req;
  logic                  tgt_ack;
  logic                  abort;
  logic                  timeout;

  wb_split_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .WIN_BITS   (WIN_BITS),
    .SEL_W      (SEL_W)
  ) u_decode (
    .adr_hi (wbs_adr_i[31:WIN_BITS]),
    .hit    (dec_hit),
    .idx    (dec_idx)
  );

  assign req   = wbs_cyc_i & wbs_stb_i;
  assign abort = ~wbs_cyc_i;
  // m_cyc_o is one-hot on the selected target, so masking ignores stray acks.
  assign tgt_ack = |(m_ack_i & m_cyc_o);
  assign m_stb_o = m_cyc_o;

  always_comb begin
    dec_onehot = '0;
    dec_onehot[dec_idx] = 1'b1;
  end

  always_comb begin
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_W'(k)) sel_rdata = m_dat_i[32*k +: 32];
    end
  end

`ifdef WB_SPLIT_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] to_cnt;

  // Held at zero while idle, so it always starts from zero on REQ entry.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      to_cnt <= '0;
    end else if (state == REQ) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout = (state == REQ) && (to_cnt == CNT_W'(TIMEOUT_CYC));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req) state_nx = dec_hit ? REQ : RESP;
      end
      REQ: begin
        if (abort)        state_nx = IDLE;
        else if (tgt_ack) state_nx = RESP;
        else if (timeout) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wbs_ack_o = (state == RESP);
    wbs_dat_o = (state == RESP) ? rdata_q : '0;
  end

  // Request registers, captured response data and error flag
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      m_cyc_o   <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      err_irq_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            m_we_o  <= wbs_we_i;
            m_sel_o <= wbs_sel_i;
            m_adr_o <= wbs_adr_i;
            m_dat_o <= wbs_dat_i;
            if (dec_hit) begin
              m_cyc_o <= dec_onehot;
              idx_q   <= dec_idx;
            end else begin
              rdata_q   <= wbs_we_i ? '0 : ERR_DATA;
              err_irq_o <= ~wbs_we_i;
            end
          end
        end
        REQ: begin
          if (abort) begin
            m_cyc_o <= '0;
          end else if (tgt_ack) begin
            m_cyc_o <= '0;
            rdata_q <= m_we_o ? '0 : sel_rdata;
          end else if (timeout) begin
            m_cyc_o   <= '0;
            err_irq_o <= 1'b1;
            rdata_q   <= m_we_o ? '0 : ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_splitter.sv
module tb_wb_slave_splitter;

  localparam int unsigned NS = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic            clk;
  logic            rst_n;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            wbs_ack;
  logic [31:0]     wbs_dat;
  logic [NS-1:0]   m_cyc, m_stb;
  logic            m_we;
  logic [3:0]      m_sel;
  logic [31:0]     m_adr, m_dato;
  logic [32*NS-1:0] m_dati;
  logic [NS-1:0]   m_ack;
  logic            err_irq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        exp_err = 1'b0;

  wb_slave_splitter #(
    .NUM_SLAVES  (NS),
    .BASE_ADDR   (32'h3000_0000),
    .WIN_BITS    (20),
    .TIMEOUT_CYC (16),
    .ERR_DATA    (ERRD)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (wbs_ack),
    .wbs_dat_o  (wbs_dat),
    .m_cyc_o    (m_cyc),
    .m_stb_o    (m_stb),
    .m_we_o     (m_we),
    .m_sel_o    (m_sel),
    .m_adr_o    (m_adr),
    .m_dat_o    (m_dato),
    .m_dat_i    (m_dati),
    .m_ack_i    (m_ack),
    .err_irq_o  (err_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference view of the address map: user area 0x30xx_xxxx, 1 MiB windows,
  // window number must be below NS.
  function automatic bit model_hit(input logic [31:0] a);
    return ((a >> 24) == 32'h30) && (((a >> 20) & 32'hF) < NS);
  endfunction

  task automatic randomize_tgt_data();
    for (int unsigned k = 0; k < NS; k++) m_dati[32*k +: 32] = $urandom;
  endtask

  // One master access; target k answers after waitc idle cycles with tdat.
  task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, input int unsigned waitc,
                        input logic [31:0] tdat);
    bit            hit;
    int unsigned   k;
    logic [NS-1:0] oh;
    hit = model_hit(a);
    k   = (a >> 20) & 32'h3;
    oh  = NS'(1) << k;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    m_ack = '0;
    randomize_tgt_data();
    chk("idle_ack", 32'(wbs_ack), 32'd0);
    next_cycle();
    if (!hit) begin
      exp_err = ~w;
      chk("miss_ack", 32'(wbs_ack), 32'd1);
      chk("miss_dat", wbs_dat, w ? 32'd0 : ERRD);
      chk("miss_err", 32'(err_irq), 32'(exp_err));
      chk("miss_cyc", 32'(m_cyc), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      next_cycle();
      chk("miss_ack_end", 32'(wbs_ack), 32'd0);
      chk("miss_dat_end", wbs_dat, 32'd0);
    end else begin
      chk("hit_cyc", 32'(m_cyc), 32'(oh));
      chk("hit_stb", 32'(m_stb), 32'(oh));
      chk("hit_adr", m_adr, a);
      chk("hit_wdat", m_dato, d);
      chk("hit_sel", 32'(m_sel), 32'(s));
      chk("hit_we", 32'(m_we), 32'(w));
      for (int unsigned j = 0; j < waitc; j++) begin
        m_ack = NS'($urandom) & ~oh;
        next_cycle();
        chk("wait_ack", 32'(wbs_ack), 32'd0);
        chk("wait_stb", 32'(m_stb), 32'(oh));
      end
      m_ack = oh | (NS'($urandom) & ~oh);
      m_dati[32*k +: 32] = tdat;
      next_cycle();
      m_ack = '0;
      chk("resp_ack", 32'(wbs_ack), 32'd1);
      chk("resp_dat", wbs_dat, w ? 32'd0 : tdat);
      chk("resp_cyc", 32'(m_cyc), 32'd0);
      chk("resp_err", 32'(err_irq), 32'(exp_err));
      cyc = 1'b0; stb = 1'b0;
      next_cycle();
      chk("resp_ack_end", 32'(wbs_ack), 32'd0);
      chk("resp_dat_end", wbs_dat, 32'd0);
    end
  endtask

  initial begin
    bit          seen;
    int unsigned cls;
    logic [31:0] ra;

    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    m_ack = '0; m_dati = '0;
    #2;
    chk("rst_ack", 32'(wbs_ack), 32'd0);
    chk("rst_dat", wbs_dat, 32'd0);
    chk("rst_cyc", 32'(m_cyc), 32'd0);
    chk("rst_adr", m_adr, 32'd0);
    chk("rst_err", 32'(err_irq), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    // Zero-wait read on target 1, then a write to target 3 with 5 waits.
    access(32'h3010_0004, 1'b0, 4'hF, 32'h0, 0, 32'h1234_5678);
    access(32'h3030_0000, 1'b1, 4'hF, 32'hA5A5_A5A5, 5, 32'h5555_0000);
    // Window index 5 is unmapped: error data and sticky flag; a write miss clears it.
    access(32'h3050_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    access(32'h2000_0000, 1'b1, 4'h3, 32'h1111_2222, 0, 32'h0);

    // Abort: master drops cyc while target 2 is stalled.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3020_0010; wdat = '0;
    next_cycle();
    chk("abort_stb", 32'(m_stb), 32'h4);
    next_cycle();
    next_cycle();
    cyc = 1'b0; stb = 1'b0;
    next_cycle();
    chk("abort_cyc", 32'(m_cyc), 32'd0);
    chk("abort_ack", 32'(wbs_ack), 32'd0);
    m_ack = 4'b0100;
    m_dati[64 +: 32] = 32'hBAD0_BAD0;
    next_cycle();
    m_ack = '0;
    chk("late_ack", 32'(wbs_ack), 32'd0);
    chk("late_cyc", 32'(m_cyc), 32'd0);
    next_cycle();
    chk("late_ack2", 32'(wbs_ack), 32'd0);
    access(32'h3020_0020, 1'b0, 4'hF, 32'h0, 2, 32'hCAFE_0002);

    // Target 0 never acknowledges.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0008;
    seen = 1'b0;
`ifdef WB_SPLIT_TIMEOUT_EN
    begin
      int unsigned ack_at;
      ack_at = 0;
      for (int unsigned c = 1; c <= 40 && !seen; c++) begin
        next_cycle();
        if (wbs_ack) begin
          seen = 1'b1;
          ack_at = c;
        end
      end
      exp_err = 1'b1;
      chk("to_cycle", ack_at, 32'd18);
      chk("to_dat", wbs_dat, ERRD);
      chk("to_err", 32'(err_irq), 32'd1);
      cyc = 1'b0; stb = 1'b0;
      next_cycle();
      chk("to_ack_end", 32'(wbs_ack), 32'd0);
    end
`else
    for (int unsigned c = 0; c < 1000; c++) begin
      next_cycle();
      if (wbs_ack) seen = 1'b1;
    end
    chk("noack_1000", 32'(seen), 32'd0);
    chk("noack_stb", 32'(m_stb), 32'h1);
    cyc = 1'b0; stb = 1'b0;
    next_cycle();
    chk("noack_abort", 32'(m_cyc), 32'd0);
    next_cycle();
`endif

    // Async reset during REQ, with the error flag set beforehand.
    access(32'h3070_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hC; adr = 32'h3030_0040; wdat = 32'h0F0F_0F0F;
    next_cycle();
    chk("pre_rst_stb", 32'(m_stb), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(m_cyc), 32'd0);
    chk("arst_adr", m_adr, 32'd0);
    chk("arst_wdat", m_dato, 32'd0);
    chk("arst_sel", 32'(m_sel), 32'd0);
    chk("arst_we", 32'(m_we), 32'd0);
    chk("arst_err", 32'(err_irq), 32'd0);
    chk("arst_ack", 32'(wbs_ack), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    next_cycle();
    chk("arst_ack_hold", 32'(wbs_ack), 32'd0);
    rst_n = 1'b1;
    exp_err = 1'b0;
    next_cycle();
    access(32'h3030_0044, 1'b0, 4'hF, 32'h0, 1, 32'h7777_8888);

    // Randomized mix of hits, window misses and foreign-base misses.
    for (int unsigned n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 9);
      if (cls <= 6) begin
        ra = {8'h30, 4'($urandom_range(0, NS - 1)), 20'($urandom)};
      end else if (cls <= 8) begin
        ra = {8'h30, 4'($urandom_range(NS, 15)), 20'($urandom)};
      end else begin
        ra = $urandom;
        if ((ra >> 24) == 32'h30) ra = ra ^ 32'h0100_0000;
      end
      access(ra, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 6), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
